// File: rtl/uart_pkg.sv
// Shared definitions for the byte-output UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
  localparam logic [31:0] UART_TX_ADDR         = 32'h1000_0000;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; push is ignored when full, pop when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rdata    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rdata    <= mem[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_byte_uart_tx.sv
// Buffers strobed CPU output bytes and serialises them as 8N1 UART frames, LSB first.
module out_byte_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int unsigned FIFO_DEPTH   = 16,
  localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [7:0]    in_byte,
  input  logic          in_byte_en,
  input  logic          overflow_clr,
  output logic          uart_tx,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          overflow_q, overflow_d;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_byte_en),
    .pop    (fifo_pop),
    .wdata  (in_byte),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // The popped byte lands in the FIFO's read register and stays put for the whole
  // start bit, so it is moved into the shift register when the start bit ends.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          baud_d   = BAUD_MAX;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_MAX;
          bit_d   = 3'd0;
          shift_d = fifo_rdata;
          state_d = StData;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StData: begin
        if (baud_q == '0) begin
          baud_d = BAUD_MAX;
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      StStop: begin
        if (baud_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            baud_d   = BAUD_MAX;
            state_d  = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level is computed from the next state so the registered output lines up with it.
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    if (in_byte_en && fifo_full) begin
      overflow_d = 1'b1;
    end else if (overflow_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign uart_tx  = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle) || (fifo_level != '0);

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Directed bench for out_byte_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_out_byte_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] in_byte;
  logic       in_byte_en;
  logic       overflow_clr;
  logic       uart_tx;
  logic       busy;
  logic [2:0] fifo_level;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Frame receiver state
  bit         rx_active = 1'b0;
  int         rx_cnt;
  logic [7:0] rx_sh;
  logic [7:0] rx_bytes[$];
  int         starts[$];
  int         frame_err = 0;
  logic [7:0] exp_q[$];

  out_byte_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_byte      (in_byte),
    .in_byte_en   (in_byte_en),
    .overflow_clr (overflow_clr),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Decodes frames by sampling mid-bit; a reset abandons any frame in progress.
  always @(negedge clk) begin
    if (!resetn) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (uart_tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        rx_sh     = '0;
        starts.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt - 6) % CPB == 0) begin
        rx_sh[(rx_cnt - 6) / CPB] = uart_tx;
      end
      if (rx_cnt == 38) begin
        if (uart_tx !== 1'b1) frame_err++;
        else rx_bytes.push_back(rx_sh);
      end
      if (rx_cnt == 39) rx_active = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b);
    in_byte    = b;
    in_byte_en = 1'b1;
    tick();
    in_byte_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit && busy; i++) tick();
    check({tag, "_idle"}, busy, 1'b0);
    tick();
    tick();
  endtask

  task automatic clear_rx();
    rx_bytes.delete();
    starts.delete();
    frame_err = 0;
  endtask

  task automatic check_rx(input string tag);
    int gaps = 0;
    check({tag, "_count"}, rx_bytes.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), (i < rx_bytes.size()) ? rx_bytes[i] : 8'hxx,
            exp_q[i]);
    end
    for (int i = 1; i < starts.size(); i++) begin
      if (starts[i] - starts[i-1] != 10 * CPB) gaps++;
    end
    check({tag, "_gaps"}, gaps, 0);
    check({tag, "_ferr"}, frame_err, 0);
  endtask

  initial begin
    int n;
    int s0;
    int lvl_max;
    bit tx_low_seen;
    logic [9:0]  frame;
    logic [39:0] wave_obs, wave_exp;

    resetn       = 1'b0;
    in_byte      = '0;
    in_byte_en   = 1'b0;
    overflow_clr = 1'b0;
    tick();
    tick();
    tick();
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_level", fifo_level, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    resetn = 1'b1;
    tick();

    // 1: single byte 0x55, exact waveform
    clear_rx();
    n = cyc;
    strobe(8'h55);
    check("t1_tx_n1", uart_tx, 1'b1);
    check("t1_busy_n1", busy, 1'b1);
    frame = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      wave_exp[j] = frame[j / CPB];
      tick();
      wave_obs[j] = uart_tx;
    end
    check("t1_cycle", cyc, n + 41);
    check("t1_wave", wave_obs, wave_exp);
    check("t1_busy_n41", busy, 1'b1);
    tick();
    check("t1_busy_n42", busy, 1'b0);
    check("t1_tx_n42", uart_tx, 1'b1);
    tick();
    tick();
    exp_q = '{8'h55};
    check_rx("t1");

    // 2: back-to-back frames
    clear_rx();
    strobe(8'h41);
    strobe(8'h42);
    strobe(8'h43);
    wait_idle("t2", 300);
    exp_q = '{8'h41, 8'h42, 8'h43};
    check_rx("t2");

    // 3: overflow on the sixth consecutive strobe
    clear_rx();
    lvl_max = 0;
    for (int i = 0; i < 6; i++) begin
      in_byte    = 8'(8'h10 + i);
      in_byte_en = 1'b1;
      tick();
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (i == 4) check("t3_ovf_before", overflow, 1'b0);
    end
    in_byte_en = 1'b0;
    check("t3_ovf_after", overflow, 1'b1);
    check("t3_level_max", lvl_max, 4);
    wait_idle("t3", 400);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("t3");

    // 4: clear, then clear coinciding with a drop
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("t4_clr", overflow, 1'b0);
    clear_rx();
    for (int i = 0; i < 5; i++) strobe(8'(8'h20 + i));
    check("t4_full", fifo_level, 3'd4);
    in_byte      = 8'h25;
    in_byte_en   = 1'b1;
    overflow_clr = 1'b1;
    tick();
    in_byte_en   = 1'b0;
    overflow_clr = 1'b0;
    check("t4_set_wins", overflow, 1'b1);
    wait_idle("t4", 400);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    check_rx("t4");

    // 5: reset during data bit 3 of 0xA5 with two bytes queued
    clear_rx();
    n = cyc;
    strobe(8'hA5);
    strobe(8'hB1);
    strobe(8'hB2);
    while (cyc < n + 19) tick();
    check("t5_level_pre", fifo_level, 3'd2);
    check("t5_tx_bit3", uart_tx, 1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("t5_tx", uart_tx, 1'b1);
    check("t5_busy", busy, 1'b0);
    check("t5_level", fifo_level, 3'd0);
    check("t5_ovf", overflow, 1'b0);
    s0 = starts.size();
    tx_low_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (uart_tx !== 1'b1) tx_low_seen = 1'b1;
    end
    check("t5_line_quiet", tx_low_seen, 1'b0);
    check("t5_no_frames", starts.size() - s0, 0);

    // 6: push while full on the last STOP cycle
    clear_rx();
    n = cyc;
    strobe(8'h61);
    tick();
    for (int i = 0; i < 4; i++) strobe(8'(8'h62 + i));
    check("t6_full", fifo_level, 3'd4);
    while (cyc < n + 41) tick();
    check("t6_ovf_pre", overflow, 1'b0);
    strobe(8'h99);
    check("t6_ovf", overflow, 1'b1);
    check("t6_level", fifo_level, 3'd3);
    wait_idle("t6", 400);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    check_rx("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
